// File: rtl/accel_obi_master_bridge_pkg.sv
// Shared types and helpers for the accelerator-to-OBI master bridge.
package accel_bridge_pkg;

   // Clock-enable FSM states.
   typedef enum logic [1:0] {
      GATED = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Width of the stall counters.
   localparam int StallCntWidth = 32;

   // Bits needed to hold an outstanding count from 0 up to max_out.
   function automatic int cnt_width(input int max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/accel_obi_master_bridge_if.sv
// Accelerator TCDM channels and OBI master ports, bundled into one interface.
// The master modport is the bridge; the slave modport is the environment
// (accelerator plus interconnect).
interface accel_obi_master_bridge_if #(
   parameter int NumPorts  = 4,
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);

   typedef struct packed {
      logic                   req;
      logic                   we;
      logic [DataWidth/8-1:0] be;
      logic [AddrWidth-1:0]   addr;
      logic [DataWidth-1:0]   wdata;
   } obi_req_t;

   typedef struct packed {
      logic                 gnt;
      logic                 rvalid;
      logic [DataWidth-1:0] rdata;
   } obi_resp_t;

   logic [NumPorts-1:0]                  tcdm_req_i;
   logic [NumPorts-1:0][AddrWidth-1:0]   tcdm_add_i;
   logic [NumPorts-1:0]                  tcdm_wen_i;
   logic [NumPorts-1:0][DataWidth/8-1:0] tcdm_be_i;
   logic [NumPorts-1:0][DataWidth-1:0]   tcdm_wdata_i;
   logic [NumPorts-1:0]                  tcdm_gnt_o;
   logic [NumPorts-1:0][DataWidth-1:0]   tcdm_rdata_o;
   logic [NumPorts-1:0]                  tcdm_r_valid_o;
   obi_req_t  [NumPorts-1:0]             masters_req_o;
   obi_resp_t [NumPorts-1:0]             masters_resp_i;

   modport master (
      input  tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_be_i, tcdm_wdata_i,
      output tcdm_gnt_o, tcdm_rdata_o, tcdm_r_valid_o,
      output masters_req_o,
      input  masters_resp_i
   );

   modport slave (
      output tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_be_i, tcdm_wdata_i,
      input  tcdm_gnt_o, tcdm_rdata_o, tcdm_r_valid_o,
      input  masters_req_o,
      output masters_resp_i
   );

endinterface

// File: rtl/accel_obi_master_bridge_chan.sv
// One bridge channel: outstanding counter, pending-request hold, sticky
// protocol error and the optional grant-stall counter.
// Optional feature macro: ACCEL_OBI_STALL_CNT_EN (stall counter present).
module accel_obi_chan
   import accel_bridge_pkg::*;
#(
   parameter int MaxOutstanding = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     run,        // FSM is in RUN: new issues allowed
   input  logic                     req,        // accelerator request
   input  logic                     gnt,        // OBI grant
   input  logic                     rvalid,     // OBI response valid
   output logic                     issue,      // OBI req
   output logic                     grant,      // grant returned to accelerator
   output logic                     busy,       // outstanding or pending work
   output logic                     err,
   output logic [StallCntWidth-1:0] stall_cnt
);

   localparam int                  CntWidth = cnt_width(MaxOutstanding);
   localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxOutstanding);

   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                pend_q;
   logic                err_q;
   logic                allow;
   logic                spurious;
   logic                dec;

   // A presented-but-ungranted request keeps its slot regardless of the FSM,
   // so an OBI request is never withdrawn before its grant.
   assign allow    = pend_q | (run & (cnt_q < MaxCnt));
   assign issue    = req & allow;
   assign grant    = issue & gnt;
   assign spurious = rvalid & (cnt_q == '0);
   assign dec      = rvalid & ~spurious;
   assign busy     = pend_q | (cnt_q != '0);
   assign err      = err_q;

   // Next outstanding count: grant adds one, a legitimate response removes one.
   always_comb begin
      // NOTE: default assigned first so no path leaves cnt_d unassigned (no latch).
      cnt_d = cnt_q;
      unique case ({grant, dec})
         2'b10:   cnt_d = cnt_q + CntWidth'(1);
         2'b01:   cnt_d = cnt_q - CntWidth'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         cnt_q  <= '0;
         pend_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= issue & ~gnt;
         if (spurious) err_q <= 1'b1;
      end
   end

`ifdef ACCEL_OBI_STALL_CNT_EN
   logic [StallCntWidth-1:0] stall_q;

   // Saturating count of cycles a presented request waits for its grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (issue && !gnt && (stall_q != '1)) begin
         stall_q <= stall_q + StallCntWidth'(1);
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: rtl/accel_obi_master_bridge.sv
// Bridges NumPorts accelerator TCDM master channels to OBI master ports and
// owns the drain-before-gate clock-enable FSM for the accelerator clock gate.
// Optional feature macro: ACCEL_OBI_STALL_CNT_EN (per-channel stall counters).
module accel_obi_master_bridge
   import accel_bridge_pkg::*;
#(
   parameter int NumPorts       = 4,
   parameter int AddrWidth      = 32,
   parameter int DataWidth      = 32,
   parameter int MaxOutstanding = 2
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   accel_enable_i,
   accel_obi_master_bridge_if.master              bus,
   output logic                                   clk_en_o,
   output logic                                   idle_o,
   output logic [NumPorts-1:0]                    err_o,
   output logic [NumPorts-1:0][StallCntWidth-1:0] stall_cnt_o
);

   state_t              state_q, state_d;
   logic                clk_en_q;
   logic                run;
   logic [NumPorts-1:0] issue;
   logic [NumPorts-1:0] grant;
   logic [NumPorts-1:0] busy;

   assign run      = (state_q == RUN);
   assign idle_o   = ~|busy;
   assign clk_en_o = clk_en_q;

   for (genvar i = 0; i < NumPorts; i++) begin : g_chan
      accel_obi_chan #(
         .MaxOutstanding (MaxOutstanding)
      ) u_chan (
         .clk       (clk_i),
         .rst_n     (rst_ni),
         .run       (run),
         .req       (bus.tcdm_req_i[i]),
         .gnt       (bus.masters_resp_i[i].gnt),
         .rvalid    (bus.masters_resp_i[i].rvalid),
         .issue     (issue[i]),
         .grant     (grant[i]),
         .busy      (busy[i]),
         .err       (err_o[i]),
         .stall_cnt (stall_cnt_o[i])
      );

      assign bus.masters_req_o[i].req   = issue[i];
      assign bus.masters_req_o[i].we    = ~bus.tcdm_wen_i[i];
      assign bus.masters_req_o[i].be    = bus.tcdm_be_i[i];
      assign bus.masters_req_o[i].addr  = bus.tcdm_add_i[i];
      assign bus.masters_req_o[i].wdata = bus.tcdm_wdata_i[i];
      assign bus.tcdm_gnt_o[i]          = grant[i];
      assign bus.tcdm_rdata_o[i]        = bus.masters_resp_i[i].rdata;
      assign bus.tcdm_r_valid_o[i]      = bus.masters_resp_i[i].rvalid;
   end

   // Next-state logic: DRAIN lets in-flight work finish before gating.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         GATED:   if (accel_enable_i) state_d = RUN;
         RUN:     if (!accel_enable_i) state_d = DRAIN;
         DRAIN: begin
            if (accel_enable_i) state_d = RUN;
            else if (idle_o)    state_d = GATED;
         end
         default: state_d = GATED;
      endcase
   end

   // State register; the clock enable is registered from the state being entered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= GATED;
         clk_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         clk_en_q <= (state_d != GATED);
      end
   end

endmodule

// File: tb/tb_accel_obi_master_bridge.sv
// Self-checking bench for accel_obi_master_bridge with a response scoreboard.
module tb_accel_obi_master_bridge;
   import accel_bridge_pkg::*;

   localparam int NumPorts       = 4;
   localparam int AddrWidth      = 32;
   localparam int DataWidth      = 32;
   localparam int MaxOutstanding = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic accel_enable;
   logic clk_en;
   logic idle;
   logic [NumPorts-1:0] err;
   logic [NumPorts-1:0][StallCntWidth-1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   // Scoreboard of expected read data (from the addresses the bench drove)
   // and the slave model's response data (from the address the DUT presented).
   logic [DataWidth-1:0] sb_q[$];
   logic [DataWidth-1:0] slv_q[$];

   always #5 clk = ~clk;

   accel_obi_master_bridge_if #(
      .NumPorts (NumPorts), .AddrWidth (AddrWidth), .DataWidth (DataWidth)
   ) bus ();

   accel_obi_master_bridge #(
      .NumPorts (NumPorts), .AddrWidth (AddrWidth),
      .DataWidth (DataWidth), .MaxOutstanding (MaxOutstanding)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .accel_enable_i (accel_enable),
      .bus            (bus.master),
      .clk_en_o       (clk_en),
      .idle_o         (idle),
      .err_o          (err),
      .stall_cnt_o    (stall_cnt)
   );

   function automatic logic [DataWidth-1:0] mem_model(input logic [AddrWidth-1:0] a);
      return a ^ 32'hA5A5_0F0F;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < NumPorts; i++) begin
         bus.tcdm_req_i[i]            = 1'b0;
         bus.tcdm_add_i[i]            = '0;
         bus.tcdm_wen_i[i]            = 1'b1;
         bus.tcdm_be_i[i]             = '0;
         bus.tcdm_wdata_i[i]          = '0;
         bus.masters_resp_i[i].gnt    = 1'b0;
         bus.masters_resp_i[i].rvalid = 1'b0;
         bus.masters_resp_i[i].rdata  = '0;
      end
   endtask

   task automatic drive_req(input int ch, input logic [AddrWidth-1:0] a,
                            input logic wen, input logic [DataWidth-1:0] wd);
      bus.tcdm_req_i[ch]   = 1'b1;
      bus.tcdm_add_i[ch]   = a;
      bus.tcdm_wen_i[ch]   = wen;
      bus.tcdm_be_i[ch]    = 4'hF;
      bus.tcdm_wdata_i[ch] = wd;
   endtask

   // Record a grant: expectation from the bench's address, slave data from the bus.
   task automatic record_grant(input int ch, input logic [AddrWidth-1:0] a);
      sb_q.push_back(mem_model(a));
      slv_q.push_back(mem_model(bus.masters_req_o[ch].addr));
   endtask

   // Slave returns one response on ch; the TCDM side must show it in the same cycle.
   task automatic respond(input int ch);
      logic [DataWidth-1:0] exp_d;
      logic [DataWidth-1:0] slv_d;
      checks++;
      if (sb_q.size() == 0 || slv_q.size() == 0) begin
         failures++;
         $display("FAIL sb_empty ch=%0d got=empty exp=entry", ch);
         return;
      end
      exp_d = sb_q.pop_front();
      slv_d = slv_q.pop_front();
      bus.masters_resp_i[ch].rvalid = 1'b1;
      bus.masters_resp_i[ch].rdata  = slv_d;
      #1;
      checks++;
      if (bus.tcdm_r_valid_o[ch] !== 1'b1) begin
         failures++;
         $display("FAIL rsp_valid ch=%0d got=%b exp=1", ch, bus.tcdm_r_valid_o[ch]);
      end
      checks++;
      if (bus.tcdm_rdata_o[ch] !== exp_d) begin
         failures++;
         $display("FAIL rsp_rdata ch=%0d got=%h exp=%h", ch, bus.tcdm_rdata_o[ch], exp_d);
      end
      step();
      bus.masters_resp_i[ch].rvalid = 1'b0;
      bus.masters_resp_i[ch].rdata  = '0;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      accel_enable = 1'b0;
      clear_inputs();
      for (int i = 0; i < NumPorts; i++) begin
         drive_req(i, 32'h10 * i, 1'b1, '0);
         bus.masters_resp_i[i].gnt = 1'b1;
      end
      #12;
      checks++;
      if (clk_en !== 1'b0) begin failures++; $display("FAIL rst_clk_en got=%b exp=0", clk_en); end
      checks++;
      if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", idle); end
      checks++;
      if (err !== '0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
      checks++;
      if (stall_cnt !== '0) begin failures++; $display("FAIL rst_stall got=%h exp=0", stall_cnt); end
      for (int i = 0; i < NumPorts; i++) begin
         checks++;
         if (bus.masters_req_o[i].req !== 1'b0 || bus.tcdm_gnt_o[i] !== 1'b0) begin
            failures++;
            $display("FAIL rst_req ch=%0d got=%b/%b exp=0/0", i,
                     bus.masters_req_o[i].req, bus.tcdm_gnt_o[i]);
         end
      end
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
      step();
      checks++;
      if (clk_en !== 1'b0) begin failures++; $display("FAIL post_rst_clk_en got=%b exp=0", clk_en); end
   endtask

   task automatic test_read();
      accel_enable = 1'b1;
      #1;
      checks++;
      if (clk_en !== 1'b0) begin failures++; $display("FAIL en_latency got=%b exp=0", clk_en); end
      step();
      checks++;
      if (clk_en !== 1'b1) begin failures++; $display("FAIL en_open got=%b exp=1", clk_en); end
      drive_req(0, 32'h0000_1000, 1'b1, '0);
      bus.tcdm_be_i[0]          = 4'h5;
      bus.masters_resp_i[0].gnt = 1'b1;
      #1;
      checks++;
      if (bus.masters_req_o[0].req !== 1'b1 || bus.tcdm_gnt_o[0] !== 1'b1) begin
         failures++;
         $display("FAIL rd_issue got=%b/%b exp=1/1", bus.masters_req_o[0].req, bus.tcdm_gnt_o[0]);
      end
      checks++;
      if (bus.masters_req_o[0].we !== 1'b0 || bus.masters_req_o[0].be !== 4'h5 ||
          bus.masters_req_o[0].addr !== 32'h0000_1000) begin
         failures++;
         $display("FAIL rd_fields got=we%b be%h a%h exp=we0 be5 a00001000",
                  bus.masters_req_o[0].we, bus.masters_req_o[0].be, bus.masters_req_o[0].addr);
      end
      record_grant(0, 32'h0000_1000);
      step();
      clear_inputs();
      #1;
      checks++;
      if (idle !== 1'b0) begin failures++; $display("FAIL rd_busy got=%b exp=0", idle); end
      step();
      respond(0);
      checks++;
      if (idle !== 1'b1) begin failures++; $display("FAIL rd_idle got=%b exp=1", idle); end
   endtask

   task automatic test_outstanding();
      logic [AddrWidth-1:0] a;
      for (int k = 0; k < 2; k++) begin
         a = 32'h0000_2000 + 32'(4 * k);
         drive_req(1, a, 1'b0, 32'h1111_0000 + 32'(k));
         bus.masters_resp_i[1].gnt = 1'b1;
         #1;
         checks++;
         if (bus.masters_req_o[1].req !== 1'b1 || bus.tcdm_gnt_o[1] !== 1'b1 ||
             bus.masters_req_o[1].we !== 1'b1 ||
             bus.masters_req_o[1].wdata !== 32'h1111_0000 + 32'(k)) begin
            failures++;
            $display("FAIL wr_issue k=%0d got=%b/%b we%b d%h exp=1/1 we1 d%h", k,
                     bus.masters_req_o[1].req, bus.tcdm_gnt_o[1], bus.masters_req_o[1].we,
                     bus.masters_req_o[1].wdata, 32'h1111_0000 + 32'(k));
         end
         record_grant(1, a);
         step();
      end
      a = 32'h0000_2008;
      drive_req(1, a, 1'b0, 32'h1111_0002);
      #1;
      checks++;
      if (bus.masters_req_o[1].req !== 1'b0 || bus.tcdm_gnt_o[1] !== 1'b0) begin
         failures++;
         $display("FAIL limit_block got=%b/%b exp=0/0", bus.masters_req_o[1].req, bus.tcdm_gnt_o[1]);
      end
      respond(1);
      #1;
      checks++;
      if (bus.masters_req_o[1].req !== 1'b1 || bus.tcdm_gnt_o[1] !== 1'b1) begin
         failures++;
         $display("FAIL limit_release got=%b/%b exp=1/1", bus.masters_req_o[1].req, bus.tcdm_gnt_o[1]);
      end
      record_grant(1, a);
      step();
      clear_inputs();
      respond(1);
      respond(1);
      checks++;
      if (idle !== 1'b1) begin failures++; $display("FAIL limit_idle got=%b exp=1", idle); end
   endtask

   task automatic test_drain();
      drive_req(0, 32'h0000_3000, 1'b1, '0);
      bus.masters_resp_i[0].gnt = 1'b1;
      #1;
      record_grant(0, 32'h0000_3000);
      step();
      drive_req(0, 32'h0000_3004, 1'b1, '0);
      bus.masters_resp_i[0].gnt = 1'b0;
      accel_enable              = 1'b0;
      step();
      #1;
      checks++;
      if (bus.masters_req_o[0].req !== 1'b1 || clk_en !== 1'b1) begin
         failures++;
         $display("FAIL drain_hold got=req%b en%b exp=req1 en1", bus.masters_req_o[0].req, clk_en);
      end
      step();
      bus.masters_resp_i[0].gnt = 1'b1;
      #1;
      checks++;
      if (bus.tcdm_gnt_o[0] !== 1'b1) begin
         failures++;
         $display("FAIL drain_gnt got=%b exp=1", bus.tcdm_gnt_o[0]);
      end
      record_grant(0, 32'h0000_3004);
      step();
      bus.masters_resp_i[0].gnt = 1'b0;
      #1;
      checks++;
      if (bus.masters_req_o[0].req !== 1'b0) begin
         failures++;
         $display("FAIL drain_no_issue got=%b exp=0", bus.masters_req_o[0].req);
      end
      respond(0);
      checks++;
      if (clk_en !== 1'b1 || idle !== 1'b0) begin
         failures++;
         $display("FAIL drain_wait got=en%b idle%b exp=en1 idle0", clk_en, idle);
      end
      bus.tcdm_req_i[0] = 1'b0;
      respond(0);
      checks++;
      if (clk_en !== 1'b1 || idle !== 1'b1) begin
         failures++;
         $display("FAIL drain_done got=en%b idle%b exp=en1 idle1", clk_en, idle);
      end
      step();
      checks++;
      if (clk_en !== 1'b0) begin failures++; $display("FAIL drain_gated got=%b exp=0", clk_en); end
   endtask

   task automatic test_reenable();
      accel_enable = 1'b1;
      step();
      drive_req(0, 32'h0000_4000, 1'b1, '0);
      bus.masters_resp_i[0].gnt = 1'b1;
      #1;
      record_grant(0, 32'h0000_4000);
      step();
      clear_inputs();
      accel_enable = 1'b0;
      step();
      accel_enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (clk_en !== 1'b1) begin
            failures++;
            $display("FAIL reen_clk_en k=%0d got=%b exp=1", k, clk_en);
         end
         step();
      end
      drive_req(0, 32'h0000_4004, 1'b1, '0);
      bus.masters_resp_i[0].gnt = 1'b1;
      #1;
      checks++;
      if (bus.masters_req_o[0].req !== 1'b1) begin
         failures++;
         $display("FAIL reen_issue got=%b exp=1", bus.masters_req_o[0].req);
      end
      record_grant(0, 32'h0000_4004);
      step();
      clear_inputs();
      respond(0);
      respond(0);
   endtask

   task automatic test_spurious();
      bus.masters_resp_i[2].rvalid = 1'b1;
      bus.masters_resp_i[2].rdata  = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (bus.tcdm_r_valid_o[2] !== 1'b1 || bus.tcdm_rdata_o[2] !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL spur_pass got=%b/%h exp=1/deadbeef", bus.tcdm_r_valid_o[2], bus.tcdm_rdata_o[2]);
      end
      step();
      clear_inputs();
      checks++;
      if (err !== 4'b0100 || idle !== 1'b1) begin
         failures++;
         $display("FAIL spur_err got=err%b idle%b exp=err0100 idle1", err, idle);
      end
      step(); step(); step();
      checks++;
      if (err !== 4'b0100) begin failures++; $display("FAIL spur_sticky got=%b exp=0100", err); end
   endtask

   task automatic test_stall();
      logic [StallCntWidth-1:0] exp_stall;
`ifdef ACCEL_OBI_STALL_CNT_EN
      exp_stall = 32'd5;
`else
      exp_stall = 32'd0;
`endif
      drive_req(3, 32'h0000_5000, 1'b1, '0);
      for (int k = 0; k < 5; k++) step();
      bus.masters_resp_i[3].gnt = 1'b1;
      #1;
      record_grant(3, 32'h0000_5000);
      step();
      clear_inputs();
      checks++;
      if (stall_cnt[3] !== exp_stall) begin
         failures++;
         $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt[3], exp_stall);
      end
      respond(3);
   endtask

   task automatic test_reset_mid();
      drive_req(0, 32'h0000_6000, 1'b1, '0);
      bus.masters_resp_i[0].gnt = 1'b1;
      step();
      clear_inputs();
      rst_n = 1'b0;
      #1;
      checks++;
      if (idle !== 1'b1 || clk_en !== 1'b0 || err !== '0 || stall_cnt !== '0) begin
         failures++;
         $display("FAIL mid_rst got=idle%b en%b err%b st%h exp=idle1 en0 err0 st0",
                  idle, clk_en, err, stall_cnt[3]);
      end
      step();
      rst_n = 1'b1;
      step();
      bus.masters_resp_i[0].rvalid = 1'b1;
      step();
      clear_inputs();
      checks++;
      if (err !== 4'b0001 || idle !== 1'b1) begin
         failures++;
         $display("FAIL mid_late_rsp got=err%b idle%b exp=err0001 idle1", err, idle);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_outstanding();
      test_drain();
      test_reenable();
      test_spurious();
      test_stall();
      test_reset_mid();
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
